// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch sequencer and its CP0 state.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0008;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [0:0] {RST, RUN} fetch_state_e;

    function automatic logic [31:0] cause_word(input logic [4:0] code);
        return {25'b0, code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_regs.sv
// EPC, Cause and Status.IE: written on a trap, IE re-enabled on eret.
module cp0_regs
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        set_trap,
    input  logic [4:0]  code,
    input  logic [31:0] epc_in,
    input  logic        eret,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic        ie
);

    logic [4:0] exc_code_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            epc        <= 32'h0;
            exc_code_q <= 5'd0;
            ie         <= 1'b0;
        end else if (set_trap) begin
            epc        <= epc_in;
            exc_code_q <= code;
            ie         <= 1'b0;
        end else if (eret) begin
            ie <= 1'b1;
        end
    end

    assign cause = cause_word(exc_code_q);

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer with exception/interrupt entry and eret return for the single-cycle core.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        irq,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic        ie,
    output logic        trap
);

    fetch_state_e state;

    logic [31:0] tgt_sel;
    logic        addr_err;
    logic [31:0] normal_next;
    logic [31:0] pc_next;
    logic        trap_req;
    logic [4:0]  trap_code;
    logic [31:0] trap_epc;
    logic        eret_take;
    logic        run;

    assign run = (state == RUN);

    always_comb begin
        tgt_sel  = jump ? jump_target : br_target;
        addr_err = (jump | br_taken) & (tgt_sel[1:0] != 2'b00);

        // The PC that would be loaded if no trap intervened; also the interrupt return point.
        if (eret)          normal_next = epc;
        else if (jump)     normal_next = jump_target;
        else if (br_taken) normal_next = br_target;
        else if (stall)    normal_next = pc;
        else               normal_next = pc + 32'd4;

        trap_req  = 1'b0;
        trap_code = EXC_INT;
        trap_epc  = pc;
        eret_take = 1'b0;
        pc_next   = normal_next;

        if (exc_req) begin
            trap_req  = 1'b1;
            trap_code = exc_code;
            pc_next   = EXC_VECTOR;
        end else if (addr_err) begin
            trap_req  = 1'b1;
            trap_code = EXC_ADEL;
            pc_next   = EXC_VECTOR;
        end else if (irq && ie && !stall) begin
            trap_req  = 1'b1;
            trap_code = EXC_INT;
            trap_epc  = normal_next;
            pc_next   = EXC_VECTOR;
        end else if (eret) begin
            eret_take = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= RST;
            pc    <= RESET_PC;
            trap  <= 1'b0;
        end else begin
            case (state)
                RST: begin
                    state <= RUN;
                    pc    <= RESET_PC;
                    trap  <= 1'b0;
                end
                RUN: begin
                    pc   <= pc_next;
                    trap <= trap_req;
                end
                default: begin
                    state <= RST;
                    pc    <= RESET_PC;
                    trap  <= 1'b0;
                end
            endcase
        end
    end

    cp0_regs u_cp0 (
        .clk      (clk),
        .clrn     (clrn),
        .set_trap (trap_req & run),
        .code     (trap_code),
        .epc_in   (trap_epc),
        .eret     (eret_take & run),
        .epc      (epc),
        .cause    (cause),
        .ie       (ie)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed vectors with hand-computed expected state.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        clrn;
    logic        stall, br_taken, jump, exc_req, irq, eret;
    logic [31:0] br_target, jump_target;
    logic [4:0]  exc_code;
    logic [31:0] pc, epc, cause;
    logic        ie, trap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic        ie;
        logic        trap;
    } exp_t;

    exp_t sb[$];

    fetch_sequencer dut (
        .clk         (clk),
        .clrn        (clrn),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .exc_req     (exc_req),
        .exc_code    (exc_code),
        .irq         (irq),
        .eret        (eret),
        .pc          (pc),
        .epc         (epc),
        .cause       (cause),
        .ie          (ie),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic chk_all(input string nm, input logic [31:0] p, input logic [31:0] e,
                           input logic [31:0] c, input logic i, input logic t);
        chk({nm, ".pc"}, pc, p);
        chk({nm, ".epc"}, epc, e);
        chk({nm, ".cause"}, cause, c);
        chk({nm, ".ie"}, {31'b0, ie}, {31'b0, i});
        chk({nm, ".trap"}, {31'b0, trap}, {31'b0, t});
    endtask

    // Monitor: every edge with a pending expectation is checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_all(e.name, e.pc, e.epc, e.cause, e.ie, e.trap);
            end
        end
    end

    task automatic clr_in();
        stall = 0; br_taken = 0; jump = 0; exc_req = 0; irq = 0; eret = 0;
        br_target = 32'h0; jump_target = 32'h0; exc_code = 5'd0;
    endtask

    // Inputs are set by the caller at a negedge; push the post-edge expectation, run one edge.
    task automatic step(input string nm, input logic [31:0] p, input logic [31:0] e,
                        input logic [31:0] c, input logic i, input logic t);
        exp_t x;
        x.name = nm; x.pc = p; x.epc = e; x.cause = c; x.ie = i; x.trap = t;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        clr_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] seq_pc;
        clr_in();
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        clrn = 1'b1;

        step("rst_edge", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        seq_pc = 32'h4;
        for (int k = 0; k < 8; k++) begin
            step("seq", seq_pc, 32'h0, 32'h0, 1'b0, 1'b0);
            seq_pc = seq_pc + 32'h4;
        end

        jump = 1; jump_target = 32'h40; br_taken = 1; br_target = 32'h80;
        step("jump_over_br", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        br_taken = 1; br_target = 32'h20;
        step("branch", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
        br_taken = 1; br_target = 32'h82;
        step("br_adel", 32'h8, 32'h20, 32'h10, 1'b0, 1'b1);
        step("trap_clear", 32'hC, 32'h20, 32'h10, 1'b0, 1'b0);

        jump = 1; jump_target = 32'h24;
        step("jump24", 32'h24, 32'h20, 32'h10, 1'b0, 1'b0);
        exc_req = 1; exc_code = 5'd12;
        step("exc_ov", 32'h8, 32'h24, 32'h30, 1'b0, 1'b1);
        step("exc_after", 32'hC, 32'h24, 32'h30, 1'b0, 1'b0);
        irq = 1;
        step("irq_masked", 32'h10, 32'h24, 32'h30, 1'b0, 1'b0);
        eret = 1;
        step("eret", 32'h24, 32'h24, 32'h30, 1'b1, 1'b0);
        step("seq28", 32'h28, 32'h24, 32'h30, 1'b1, 1'b0);
        step("seq2c", 32'h2C, 32'h24, 32'h30, 1'b1, 1'b0);
        step("seq30", 32'h30, 32'h24, 32'h30, 1'b1, 1'b0);
        irq = 1; stall = 1;
        step("irq_stall1", 32'h30, 32'h24, 32'h30, 1'b1, 1'b0);
        irq = 1; stall = 1;
        step("irq_stall2", 32'h30, 32'h24, 32'h30, 1'b1, 1'b0);
        irq = 1;
        step("irq_take", 32'h8, 32'h34, 32'h0, 1'b0, 1'b1);
        irq = 1;
        step("irq_ie0", 32'hC, 32'h34, 32'h0, 1'b0, 1'b0);
        eret = 1;
        step("eret2", 32'h34, 32'h34, 32'h0, 1'b1, 1'b0);
        eret = 1; irq = 1;
        step("eret_irq", 32'h8, 32'h34, 32'h0, 1'b0, 1'b1);
        exc_req = 1; exc_code = 5'd8;
        step("nested_sys", 32'h8, 32'h8, 32'h20, 1'b0, 1'b1);
        exc_req = 1; exc_code = 5'd10; stall = 1;
        step("exc_stall", 32'h8, 32'h8, 32'h28, 1'b0, 1'b1);
        stall = 1;
        step("stall", 32'h8, 32'h8, 32'h28, 1'b0, 1'b0);
        jump = 1; jump_target = 32'h40; br_taken = 1; br_target = 32'h82;
        step("jump_masks_bad_br", 32'h40, 32'h8, 32'h28, 1'b0, 1'b0);
        jump = 1; jump_target = 32'h41;
        step("jump_adel", 32'h8, 32'h40, 32'h10, 1'b0, 1'b1);
        jump = 1; jump_target = 32'hFFFF_FFFC;
        step("jump_top", 32'hFFFF_FFFC, 32'h40, 32'h10, 1'b0, 1'b0);
        step("wrap", 32'h0, 32'h40, 32'h10, 1'b0, 1'b0);
        exc_req = 1; exc_code = 5'd12;
        step("pre_rst_trap", 32'h8, 32'h0, 32'h30, 1'b0, 1'b1);

        // Trap pulse is high now; reset asserted mid-cycle must clear state before the edge.
        clrn = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        exc_req = 1; exc_code = 5'd12; jump = 1; jump_target = 32'h40;
        step("rst_ignores_req", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("post_rst_seq", 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
